sweep_sequencer: RTL and testbench

Command-driven controller that sequences a W-bit up/down bounce counter between programmable endpoints for a programmed number of sweeps. It holds at each turnaround point, supports pause and abort, and reports completion. It sits between a command source (register block or upstream FSM) and the W-bit counter value consumed by downstream display/test logic. It replaces a free-running fixed 0..15 bounce with a configurable, start/stop-controlled sequence.

---
 rtl/sweep_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sweep_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// Command-driven up/down bounce counter between programmable endpoints.
// Define SWEEP_SEQ_DWELL_EN to hold each intermediate endpoint for 1+DWELL cycles.
module sweep_sequencer #(
  parameter int W     = 4,
  parameter int CNTW  = 8,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_lo,
  input  logic [W-1:0]    cmd_hi,
  input  logic [CNTW-1:0] cmd_sweeps,
  input  logic            pause,
  input  logic            abort,
  output logic [W-1:0]    s,
  output logic            dir,
  output logic            busy,
  output logic            edge_pulse,
  output logic            done,
  output logic            err
);

`ifdef SWEEP_SEQ_DWELL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DWELL, ST_DONE} state_t;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DCW-1:0] dwell_cnt_q, dwell_cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [W-1:0]    s_q, s_d, lo_q, lo_d, hi_q, hi_d;
  logic            dir_q, dir_d, edge_q, edge_d, err_q, err_d;
  logic [CNTW-1:0] sw_q, sw_d;
  logic [W-1:0]    step, target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dir_q   <= 1'b0;
      edge_q  <= 1'b0;
      err_q   <= 1'b0;
      sw_q    <= '0;
`ifdef SWEEP_SEQ_DWELL_EN
      dwell_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dir_q   <= dir_d;
      edge_q  <= edge_d;
      err_q   <= err_d;
      sw_q    <= sw_d;
`ifdef SWEEP_SEQ_DWELL_EN
      dwell_cnt_q <= dwell_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dir_d   = dir_q;
    edge_d  = 1'b0;
    err_d   = err_q;
    sw_d    = sw_q;
`ifdef SWEEP_SEQ_DWELL_EN
    dwell_cnt_d = dwell_cnt_q;
`endif
    step   = dir_q ? s_q - W'(1) : s_q + W'(1);
    target = dir_q ? lo_q : hi_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (cmd_valid) begin
          lo_d = cmd_lo;
          hi_d = cmd_hi;
          if (cmd_lo >= cmd_hi || cmd_sweeps == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            s_d     = cmd_lo;
            dir_d   = 1'b0;
            sw_d    = cmd_sweeps;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (!pause) begin
          // sweeps_left hits zero when the final endpoint is written; that value
          // stays on s for one cycle before the done pulse.
          if (sw_q == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b0;
          end else begin
            s_d = step;
            if (step == target) begin
              edge_d = 1'b1;
              sw_d   = sw_q - CNTW'(1);
              if (sw_q != CNTW'(1)) begin
`ifdef SWEEP_SEQ_DWELL_EN
                state_d     = ST_DWELL;
                dwell_cnt_d = '0;
`else
                dir_d = ~dir_q;
`endif
              end
            end
          end
        end
      end
`ifdef SWEEP_SEQ_DWELL_EN
      ST_DWELL: begin
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (!pause) begin
          if (dwell_cnt_q == DCW'(DWELL - 1)) begin
            dir_d   = ~dir_q;
            state_d = ST_RUN;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DCW'(1);
          end
        end
      end
`endif
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
`ifdef SWEEP_SEQ_DWELL_EN
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DWELL);
`else
  assign busy       = (state_q == ST_RUN);
`endif
  assign s          = s_q;
  assign dir        = dir_q;
  assign edge_pulse = edge_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Randomized bench for sweep_sequencer: per-command expected output trace is built
// from the sweep rules, then edited live for pause/abort.
module tb_sweep_sequencer;
  localparam int W = 4, CNTW = 8, DWELL = 1;

  logic            clk = 1'b0, rst = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0]    cmd_lo = '0, cmd_hi = '0;
  logic [CNTW-1:0] cmd_sweeps = '0;
  logic            pause = 1'b0, abort = 1'b0;
  logic [W-1:0]    s;
  logic            dir, busy, edge_pulse, done, err;

  sweep_sequencer #(.W(W), .CNTW(CNTW), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_sweeps(cmd_sweeps),
    .pause(pause), .abort(abort), .s(s), .dir(dir), .busy(busy),
    .edge_pulse(edge_pulse), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         dir;
    logic         ep;
    logic         done;
    logic         err;
  } ent_t;

  ent_t         q[$];
  int           n_chk = 0, n_err = 0;
  logic [W-1:0] prev_s = '0;
  logic         prev_dir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected cycle-by-cycle outputs from T+1 through the done cycle, no pause/abort.
  task automatic build(input logic [W-1:0] lo, input logic [W-1:0] hi, input int sw);
    logic [W-1:0] cur, tgt;
    logic         d;
    q.delete();
    if (lo >= hi || sw == 0) begin
      q.push_back('{prev_s, prev_dir, 1'b0, 1'b1, 1'b1});
      return;
    end
    cur = lo;
    d   = 1'b0;
    q.push_back('{cur, d, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < sw; k++) begin
      tgt = d ? lo : hi;
      while (cur != tgt) begin
        cur = d ? cur - 4'd1 : cur + 4'd1;
        q.push_back('{cur, d, (cur == tgt), 1'b0, 1'b0});
      end
      if (k != sw - 1) begin
`ifdef SWEEP_SEQ_DWELL_EN
        for (int j = 0; j < DWELL; j++)
          q.push_back('{cur, (j == DWELL - 1) ? !d : d, 1'b0, 1'b0, 1'b0});
        d = !d;
`else
        d = !d;
        q[$].dir = d;
`endif
      end
    end
    q.push_back('{cur, d, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic run_cmd(input logic [W-1:0] lo, input logic [W-1:0] hi, input int sw,
                         input int pprob, input int ab_s, input int hold_s, input int hold_n,
                         input int exp_cyc);
    ent_t e;
    int   idx, cyc, hn;
    logic p, a, fin, aborted;
    chk("rdy", 32'(cmd_ready), 32'd1);
    cmd_lo = lo; cmd_hi = hi; cmd_sweeps = CNTW'(sw); cmd_valid = 1'b1;
    build(lo, hi, sw);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    idx = 0; cyc = 1; fin = 1'b0; aborted = 1'b0; hn = hold_n;
    while (!fin) begin
      e = q[idx];
      chk("s", 32'(s), 32'(e.s));
      chk("st", 32'({dir, busy, edge_pulse, done, done & err, cmd_ready}),
          32'({e.dir, !e.done, e.ep, e.done, e.err, 1'b0}));
      if (e.done) begin
        if (exp_cyc > 0) chk("done_cyc", 32'(cyc), 32'(exp_cyc));
        prev_s = e.s; prev_dir = e.dir; fin = 1'b1;
      end else begin
        p = ($urandom_range(99) < 32'(pprob));
        a = 1'b0;
        if (hn > 0 && 32'(e.s) == 32'(hold_s)) begin p = 1'b1; hn--; end
        if (!aborted && ab_s >= 0 && 32'(e.s) == 32'(ab_s)) begin a = 1'b1; aborted = 1'b1; end
        pause = p; abort = a;
        @(posedge clk); #1;
        pause = 1'b0; abort = 1'b0;
        cyc++;
        if (a) begin
          q.delete();
          q.push_back('{e.s, e.dir, 1'b0, 1'b1, 1'b1});
          idx = 0;
        end else if (p) q[idx].ep = 1'b0;
        else idx++;
        if (cyc > 400) begin chk("timeout", 32'(cyc), 32'd0); fin = 1'b1; end
      end
    end
    // First idle cycle: abort/pause must be ignored, values held, ready again.
    abort = 1'($urandom_range(1)); pause = 1'($urandom_range(1));
    @(posedge clk); #1;
    abort = 1'b0; pause = 1'b0;
    chk("idle_s", 32'(s), 32'(prev_s));
    chk("idle_st", 32'({dir, busy, edge_pulse, done, cmd_ready}), 32'({prev_dir, 4'b0001}));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_st", 32'({dir, busy, edge_pulse, done, err, cmd_ready}), 32'b000001);

    // directed cases
    run_cmd(4'd0, 4'd3, 2, 0, -1, -1, 0,
`ifdef SWEEP_SEQ_DWELL_EN
            9);
`else
            8);
`endif
    run_cmd(4'd5, 4'd5, 3, 0, -1, -1, 0, 1);
    run_cmd(4'd0, 4'd15, 1, 0, -1, 7, 3, 20);
    run_cmd(4'd0, 4'd15, 1, 0, 9, -1, 0, 11);
    run_cmd(4'd9, 4'd2, 1, 0, -1, -1, 0, 1);
    run_cmd(4'd0, 4'd15, 2, 0, -1, -1, 0, 0);
    run_cmd(4'd3, 4'd4, 0, 0, -1, -1, 0, 1);

    // reset in mid-run
    cmd_lo = 4'd2; cmd_hi = 4'd12; cmd_sweeps = 8'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_st", 32'({dir, busy, edge_pulse, done, err, cmd_ready}), 32'b000001);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_s", 32'(s), 32'd0);
    chk("rel_st", 32'({dir, busy, edge_pulse, done, err, cmd_ready}), 32'b000001);
    prev_s = '0; prev_dir = 1'b0;

    // randomized commands with random pause and occasional abort
    for (int n = 0; n < 30; n++) begin
      run_cmd(W'($urandom_range(15)), W'($urandom_range(15)), int'($urandom_range(4)), 20,
              ($urandom_range(4) == 0) ? int'($urandom_range(15)) : -1, -1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
